// File: rtl/add_mul_arbiter_4_bit.sv
// Two-requester arbiter for a shared combinational 4-bit add/multiply datapath.
// Operands are registered onto the datapath, settled for EXEC_CYCLES, then returned.
module add_mul_arbiter_4_bit #(
   parameter int unsigned EXEC_CYCLES = 1,
   parameter bit          RR_EN       = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic       req0_op,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic       req1_op,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   output logic       resp0_valid,
   input  logic       resp0_ready,
   output logic [7:0] resp0_data,
   output logic       resp1_valid,
   input  logic       resp1_ready,
   output logic [7:0] resp1_data,
   output logic [3:0] dp_a,
   output logic [3:0] dp_b,
   input  logic [7:0] dp_mul,
   input  logic [3:0] dp_add,
   output logic       busy
);

   localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t     state_q, state_d;
   logic       ptr_q, ptr_d;
   logic       owner_q, owner_d;
   logic       op_q, op_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] res_q, res_d;
   logic       busy_q;
   logic       winner;
   logic       grant;
   logic       resp_hs;

   // Contention goes to the pointer's requester only in round-robin mode.
   always_comb begin
      winner = 1'b0;
      if (req0_valid && req1_valid) begin
         winner = RR_EN ? ptr_q : 1'b0;
      end else begin
         winner = req1_valid;
      end
      grant   = (state_q == IDLE) && (req0_valid || req1_valid);
      resp_hs = (state_q == RESP) && (owner_q ? resp1_ready : resp0_ready);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         owner_q <= 1'b0;
         op_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (grant) begin
               owner_d = winner;
               op_d    = winner ? req1_op : req0_op;
               a_d     = winner ? req1_a : req0_a;
               b_d     = winner ? req1_b : req0_b;
               cnt_d   = CNT_LOAD;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
               res_d   = op_q ? dp_mul : {4'b0000, dp_add};
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_hs) begin
               state_d = IDLE;
               if (RR_EN) begin
                  ptr_d = ~owner_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Ready is masked by reset so every output reads 0 while reset is held.
   always_comb begin
      req0_ready  = grant && !winner && rst_n;
      req1_ready  = grant && winner && rst_n;
      resp0_valid = (state_q == RESP) && !owner_q;
      resp1_valid = (state_q == RESP) && owner_q;
      resp0_data  = resp0_valid ? res_q : '0;
      resp1_data  = resp1_valid ? res_q : '0;
      dp_a        = a_q;
      dp_b        = b_q;
      busy        = busy_q;
   end

endmodule

// File: tb/tb_add_mul_arbiter_4_bit.sv
// Randomized bench for add_mul_arbiter_4_bit: three configurations checked cycle by
// cycle against a transaction-level model of acceptance, settle time and response.
module tb_add_mul_arbiter_4_bit;

   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       rst_n  [NI];
   logic       rq_v   [NI][2];
   logic       rq_r   [NI][2];
   logic       rq_op  [NI][2];
   logic [3:0] rq_a   [NI][2];
   logic [3:0] rq_b   [NI][2];
   logic       rs_v   [NI][2];
   logic       rs_r   [NI][2];
   logic [7:0] rs_d   [NI][2];
   logic [3:0] dp_a   [NI];
   logic [3:0] dp_b   [NI];
   logic [7:0] dp_mul [NI];
   logic [3:0] dp_add [NI];
   logic       busy   [NI];
   logic       glitch [NI];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic int exec_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
   endfunction

   function automatic bit rr_of(input int k);
      return (k != 2);
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      add_mul_arbiter_4_bit #(
         .EXEC_CYCLES(exec_of(g)),
         .RR_EN      (rr_of(g))
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n[g]),
         .req0_valid (rq_v[g][0]),
         .req0_ready (rq_r[g][0]),
         .req0_op    (rq_op[g][0]),
         .req0_a     (rq_a[g][0]),
         .req0_b     (rq_b[g][0]),
         .req1_valid (rq_v[g][1]),
         .req1_ready (rq_r[g][1]),
         .req1_op    (rq_op[g][1]),
         .req1_a     (rq_a[g][1]),
         .req1_b     (rq_b[g][1]),
         .resp0_valid(rs_v[g][0]),
         .resp0_ready(rs_r[g][0]),
         .resp0_data (rs_d[g][0]),
         .resp1_valid(rs_v[g][1]),
         .resp1_ready(rs_r[g][1]),
         .resp1_data (rs_d[g][1]),
         .dp_a       (dp_a[g]),
         .dp_b       (dp_b[g]),
         .dp_mul     (dp_mul[g]),
         .dp_add     (dp_add[g]),
         .busy       (busy[g])
      );

      // Datapath presents inverted (wrong) values until the final settle cycle.
      assign dp_mul[g] = glitch[g] ? ~({4'b0000, dp_a[g]} * {4'b0000, dp_b[g]})
                                   :  ({4'b0000, dp_a[g]} * {4'b0000, dp_b[g]});
      assign dp_add[g] = glitch[g] ? ~(dp_a[g] + dp_b[g]) : (dp_a[g] + dp_b[g]);
   end

   task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [39:0] all_outs(input int k);
      return 40'({rq_r[k][1], rq_r[k][0], rs_v[k][1], rs_v[k][0], rs_d[k][1], rs_d[k][0],
                  busy[k], dp_a[k], dp_b[k]});
   endfunction

   task automatic run_inst(input int k);
      int         ex;
      bit         rr;
      int         c;
      bit         infl;
      int         acc;
      int         own;
      int         last;
      int         win;
      int         bp;
      bit         any;
      bit         did_rst;
      bit         pend [2];
      logic [7:0] res;
      logic [3:0] ma, mb;
      logic [1:0] e_rdy, e_rv;
      logic [7:0] e_d0, e_d1;
      string      pfx;

      ex = exec_of(k);
      rr = rr_of(k);
      c = 0; infl = 0; acc = 0; own = 0; last = 1; bp = 0; did_rst = 0;
      res = '0; ma = '0; mb = '0;
      glitch[k] = 1'b0;
      rs_r[k][0] = 1'b1;
      rs_r[k][1] = 1'b1;
      // Both requesters present at reset exit: req0 mul 15x15, req1 add 2+3.
      rq_v[k][0] = 1'b1; rq_op[k][0] = 1'b1; rq_a[k][0] = 4'd15; rq_b[k][0] = 4'd15;
      rq_v[k][1] = 1'b1; rq_op[k][1] = 1'b0; rq_a[k][1] = 4'd2;  rq_b[k][1] = 4'd3;
      pend[0] = 1'b1;
      pend[1] = 1'b1;
      rst_n[k] = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk($sformatf("i%0d reset_outs", k), all_outs(k), '0);
      @(negedge clk);
      rst_n[k] = 1'b1;

      for (int i = 0; i < 1500; i++) begin
         pfx = $sformatf("i%0d c%0d", k, c);
         if (i > 0) begin
            for (int r = 0; r < 2; r++) begin
               if (!pend[r]) begin
                  rq_v[k][r]  = ($urandom % 3) != 0;
                  rq_op[k][r] = 1'($urandom);
                  rq_a[k][r]  = 4'($urandom);
                  rq_b[k][r]  = 4'($urandom);
                  pend[r]     = rq_v[k][r];
               end
            end
            if (bp == 0 && ($urandom % 40) == 0) bp = 10;
            if (bp > 0) begin
               rs_r[k][0] = 1'b0;
               rs_r[k][1] = 1'b0;
               bp--;
            end else begin
               rs_r[k][0] = ($urandom % 4) != 0;
               rs_r[k][1] = ($urandom % 4) != 0;
            end
         end
         glitch[k] = infl && (c < acc + ex);

         if (infl && c == acc + 2 && (!did_rst || ($urandom % 6) == 0)) begin
            did_rst   = 1'b1;
            rst_n[k]  = 1'b0;
            glitch[k] = 1'b0;
            #1;
            chk({pfx, " abort_outs"}, all_outs(k), '0);
            infl = 0; last = 1; ma = '0; mb = '0; res = '0;
            @(posedge clk);
            c++;
            @(negedge clk);
            rst_n[k] = 1'b1;
            continue;
         end

         #1;
         any = rq_v[k][0] || rq_v[k][1];
         if (rq_v[k][0] && rq_v[k][1]) win = rr ? ((last == 0) ? 1 : 0) : 0;
         else                          win = rq_v[k][1] ? 1 : 0;
         if (!infl) begin
            e_rdy = any ? ((win == 1) ? 2'b10 : 2'b01) : 2'b00;
            e_rv  = 2'b00;
         end else begin
            e_rdy = 2'b00;
            e_rv  = (c >= acc + ex + 1) ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00;
         end
         e_d0 = e_rv[0] ? res : 8'h00;
         e_d1 = e_rv[1] ? res : 8'h00;
         chk({pfx, " req_ready"},  40'({rq_r[k][1], rq_r[k][0]}), 40'(e_rdy));
         chk({pfx, " resp_valid"}, 40'({rs_v[k][1], rs_v[k][0]}), 40'(e_rv));
         chk({pfx, " resp0_data"}, 40'(rs_d[k][0]), 40'(e_d0));
         chk({pfx, " resp1_data"}, 40'(rs_d[k][1]), 40'(e_d1));
         chk({pfx, " busy"},       40'(busy[k]), 40'(infl));
         chk({pfx, " dp_ab"},      40'({dp_a[k], dp_b[k]}), 40'({ma, mb}));

         @(posedge clk);
         if (!infl && any) begin
            infl = 1;
            acc  = c;
            own  = win;
            ma   = rq_a[k][win];
            mb   = rq_b[k][win];
            res  = rq_op[k][win] ? 8'(int'(ma) * int'(mb)) : 8'((int'(ma) + int'(mb)) % 16);
            pend[win] = 1'b0;
         end else if (infl && e_rv != 2'b00 && rs_r[k][own]) begin
            infl = 0;
            if (rr) last = own;
         end
         c++;
         @(negedge clk);
      end
      rq_v[k][0] = 1'b0;
      rq_v[k][1] = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         rst_n[k]  = 1'b0;
         glitch[k] = 1'b0;
         for (int r = 0; r < 2; r++) begin
            rq_v[k][r]  = 1'b0;
            rq_op[k][r] = 1'b0;
            rq_a[k][r]  = '0;
            rq_b[k][r]  = '0;
            rs_r[k][r]  = 1'b0;
         end
      end
      for (int k = 0; k < NI; k++) begin
         run_inst(k);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
